mem_bus_arbiter: RTL

Two-requester arbiter that shares a single memory port (address, write data, write enable) between two processor cores in the multi-processor build. Each core raises a request and drives its address, data-out and write strobe. The arbiter grants one core at a time using round-robin priority and muxes the granted core's bus onto the memory. A one-cycle turnaround is inserted between owners so the memory never sees a write from a core that has just lost its grant.

---
 rtl/mem_bus_arbiter.sv | 139 +++++++++++++
 1 files changed

// File: rtl/mem_bus_arbiter.sv
// mem_bus_arbiter
//   Round-robin arbiter sharing one memory port between two cores.
//   A single dead (TURN) cycle separates consecutive owners, so a write
//   strobe from a core that has just lost the bus never reaches memory.
//
//   Optional feature: define ARB_HOLD_LIMIT_EN to bound a grant to MAX_HOLD
//   consecutive cycles whenever the other core is waiting.
//
// Ports
//   clock            rising-edge clock
//   resetN           synchronous, active-high reset
//   req0/req1        level requests from core 0 / core 1
//   addr0/addr1      core addresses (AW bits)
//   dout0/dout1      core write data (DW bits)
//   w0/w1            core write strobes
//   gnt0/gnt1        grants, decoded from the state register
//   mem_addr         owner's address, 0 with no owner
//   mem_dout         owner's write data, 0 with no owner
//   mem_w            owner's write strobe, 0 with no owner
//   owner            index of the most recently granted core
module mem_bus_arbiter #(
  parameter int DW       = 16,
  parameter int AW       = 16,
  parameter int MAX_HOLD = 8
) (
  input  logic          clock,
  input  logic          resetN,
  input  logic          req0,
  input  logic          req1,
  input  logic [AW-1:0] addr0,
  input  logic [AW-1:0] addr1,
  input  logic [DW-1:0] dout0,
  input  logic [DW-1:0] dout1,
  input  logic          w0,
  input  logic          w1,
  output logic          gnt0,
  output logic          gnt1,
  output logic [AW-1:0] mem_addr,
  output logic [DW-1:0] mem_dout,
  output logic          mem_w,
  output logic          owner
);

  typedef enum logic [1:0] {IDLE, GNT0, GNT1, TURN} state_t;

  state_t state_reg, state_next;
  logic   last_reg, last_next;
  logic   cut0, cut1;

  // The hold counter is 8 bits wide, so MAX_HOLD must fit in it.
  if (MAX_HOLD < 2 || MAX_HOLD > 255) begin : g_bad_max_hold
    $error("mem_bus_arbiter: MAX_HOLD must be in 2..255");
  end

`ifdef ARB_HOLD_LIMIT_EN
  logic [7:0] hold_reg, hold_next;
  logic       hold_expired;

  assign hold_expired = (hold_reg == 8'(MAX_HOLD - 1));
  // Preempt the owner only when its budget is spent and the peer is waiting.
  assign cut0 = hold_expired && req1;
  assign cut1 = hold_expired && req0;

  always_comb begin
    hold_next = hold_reg;
    if ((state_next == GNT0 || state_next == GNT1) && state_next != state_reg)
      hold_next = 8'd0;
    else if ((state_reg == GNT0 || state_reg == GNT1) && !hold_expired)
      hold_next = hold_reg + 8'd1;  // saturates at MAX_HOLD-1
  end

  always_ff @(posedge clock) begin
    if (resetN) hold_reg <= 8'd0;
    else        hold_reg <= hold_next;
  end
`else
  assign cut0 = 1'b0;
  assign cut1 = 1'b0;
`endif

  // State register
  always_ff @(posedge clock) begin
    if (resetN) begin
      state_reg <= IDLE;
      last_reg  <= 1'b1;   // core 0 wins the first tie
    end else begin
      state_reg <= state_next;
      last_reg  <= last_next;
    end
  end

  // Next-state logic
  always_comb begin
    state_next = state_reg;
    case (state_reg)
      IDLE, TURN: begin
        // TURN applies the same decision as IDLE so a waiting core is
        // granted right after the single dead cycle.
        if (req0 && req1)  state_next = last_reg ? GNT0 : GNT1;
        else if (req0)     state_next = GNT0;
        else if (req1)     state_next = GNT1;
        else               state_next = IDLE;
      end
      GNT0:    if (!req0 || cut0) state_next = TURN;
      GNT1:    if (!req1 || cut1) state_next = TURN;
      default: state_next = IDLE;
    endcase

    last_next = last_reg;
    if (state_next == GNT0)      last_next = 1'b0;
    else if (state_next == GNT1) last_next = 1'b1;
  end

  // Output logic: grants and memory mux decoded from the state register.
  always_comb begin
    gnt0     = 1'b0;
    gnt1     = 1'b0;
    mem_addr = '0;
    mem_dout = '0;
    mem_w    = 1'b0;
    owner    = last_reg;
    case (state_reg)
      GNT0: begin
        gnt0     = 1'b1;
        mem_addr = addr0;
        mem_dout = dout0;
        mem_w    = w0;
      end
      GNT1: begin
        gnt1     = 1'b1;
        mem_addr = addr1;
        mem_dout = dout1;
        mem_w    = w1;
      end
      default: ;
    endcase
  end

endmodule
